// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_pkg: shared key codes, FSM state type and hex glyph decoder   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package keypad_pkg;

  localparam logic [3:0] KEY_BKSP   = 4'hE;
  localparam logic [3:0] KEY_CLR    = 4'hF;
  localparam int         NUM_DIGITS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_state_e;

  // Active-low glyphs, bit 0 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_entry_buffer_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_scan: time-multiplexes the digit buffer onto 8 seven-seg     |
// | digits, blanking slots at or beyond the valid count. Revision: 1.0   |
// +----------------------------------------------------------------------+
module display_scan
  import keypad_pkg::*;
#(
  parameter int REFRESH_DIV = 10000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] digits_i,
  input  logic [3:0]  count_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o
);

  localparam int            PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit_w;
  logic          lit_w;

  assign digit_w = digits_i[{idx_q, 2'b00} +: 4];
  assign lit_w   = ({1'b0, idx_q} < count_i);

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    if (lit_w) begin
      an_d[idx_q] = 1'b0;
      seg_d       = hex_to_seg(digit_w);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule
`default_nettype wire

// File: rtl/key_entry_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_entry_buffer: eight-digit key entry shift buffer with backspace, |
// | clear and overflow flag, plus scanned display. Revision: 1.0         |
// +----------------------------------------------------------------------+
module key_entry_buffer
  import keypad_pkg::*;
#(
  parameter int REFRESH_DIV = 10000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  key_value_i,
  input  logic        data_available_i,
  output logic [31:0] digits_o,
  output logic [3:0]  count_o,
  output logic        full_o,
  output logic        overflow_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o
);

  localparam logic [3:0] LAST_SLOT = 4'(NUM_DIGITS - 1);

  key_state_e  state_q;
  logic [31:0] digits_q;
  logic [3:0]  count_q;
  logic        full_q;
  logic        overflow_q;

  // One action per press: the FSM waits in HELD until the key is released.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      digits_q   <= 32'h0;
      count_q    <= 4'd0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_available_i) begin
            state_q <= HELD;
            case (key_value_i)
              KEY_CLR: begin
                digits_q <= 32'h0;
                count_q  <= 4'd0;
                full_q   <= 1'b0;
              end
              KEY_BKSP: begin
                if (count_q != 4'd0) begin
                  digits_q <= {4'h0, digits_q[31:4]};
                  count_q  <= count_q - 4'd1;
                  full_q   <= 1'b0;
                end
              end
              default: begin
                if (full_q) begin
                  overflow_q <= 1'b1;
                end else begin
                  digits_q <= {digits_q[27:0], key_value_i};
                  count_q  <= count_q + 4'd1;
                  full_q   <= (count_q == LAST_SLOT);
                end
              end
            endcase
          end
        end
        HELD: begin
          if (!data_available_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digits_o   = digits_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

  display_scan #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_display_scan (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .digits_i(digits_q),
    .count_i (count_q),
    .an_o    (an_o),
    .seg_o   (seg_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_key_entry_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_key_entry_buffer: scoreboard bench with a queue-based buffer model |
// | and an arithmetic scan-position model. Revision: 1.0                  |
// +----------------------------------------------------------------------+
module tb_key_entry_buffer;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key = 4'h0;
  logic        dav = 1'b0;
  logic [31:0] digits_o;
  logic [3:0]  count_o;
  logic        full_o;
  logic        overflow_o;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;

  always #5 clk = ~clk;

  key_entry_buffer #(.REFRESH_DIV(R)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .key_value_i     (key),
    .data_available_i(dav),
    .digits_o        (digits_o),
    .count_o         (count_o),
    .full_o          (full_o),
    .overflow_o      (overflow_o),
    .an_o            (an_o),
    .seg_o           (seg_o)
  );

  // Clock edges seen since reset was last released.
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    int          n;
    logic        ovf;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mdl[$];   // mdl[0] is the newest digit
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at t=%0t cyc=%0d: got %h expected %h", name, $time, cyc, act, req);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [31:0] mdl_word();
    logic [31:0] w = 32'h0;
    foreach (mdl[k]) w[4*k +: 4] = mdl[k];
    return w;
  endfunction

  // Returns 1 when the key is a digit rejected because the buffer is full.
  function automatic logic model_apply(input logic [3:0] k);
    if (k == 4'hF) mdl.delete();
    else if (k == 4'hE) begin
      if (mdl.size() > 0) void'(mdl.pop_front());
    end else if (mdl.size() == 8) return 1'b1;
    else mdl.push_front(k);
    return 1'b0;
  endfunction

  task automatic push_exp(input int c, input logic ovf);
    exp_t e;
    e.cyc = c;
    e.d   = mdl_word();
    e.n   = mdl.size();
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Press k for 'hold' sampled edges, then leave 'gap' low edges.
  task automatic press(input logic [3:0] k, input int hold, input int gap);
    int c0;
    logic ovf;
    @(negedge clk);
    key = k;
    dav = 1'b1;
    c0  = cyc;
    ovf = model_apply(k);
    push_exp(c0 + 1, ovf);
    push_exp(c0 + 2, 1'b0);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      key = 4'($urandom);
    end
    if (hold > 1) push_exp(c0 + hold + 1, 1'b0);
    @(negedge clk);
    dav = 1'b0;
    for (int i = 1; i < gap; i++) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: display every cycle from the last confirmed buffer state,
  // then buffer outputs whenever a scoreboard entry falls due.
  logic [31:0] cur_d;
  int          cur_n;
  initial begin
    exp_t        e;
    int          idx;
    logic [7:0]  ea;
    logic [6:0]  es;
    cur_d = 32'h0;
    cur_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_d = 32'h0;
        cur_n = 0;
      end else begin
        ea = 8'hFF;
        es = 7'h7F;
        if (cyc > 0) begin
          idx = ((cyc - 1) / R) % 8;
          if (idx < cur_n) begin
            ea[idx] = 1'b0;
            es      = glyph(cur_d[4*idx +: 4]);
          end
        end
        check("an_o", 32'(an_o), 32'(ea));
        check("seg_o", 32'(seg_o), 32'(es));
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          check("sb_due_cycle", 32'(cyc), 32'(e.cyc));
          check("digits_o", digits_o, e.d);
          check("count_o", 32'(count_o), 32'(e.n));
          check("full_o", 32'(full_o), 32'(e.n == 8));
          check("overflow_o", 32'(overflow_o), 32'(e.ovf));
          cur_d = e.d;
          cur_n = e.n;
        end
      end
    end
  end

  initial begin
    int r;
    // Reset values while reset is held.
    #12;
    check("rst_digits", digits_o, 32'h0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_an", 32'(an_o), 32'hFF);
    check("rst_seg", 32'(seg_o), 32'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    press(4'h3, 1, 2);
    repeat (40) @(negedge clk);
    press(4'hF, 1, 1);
    for (int i = 1; i <= 4; i++) press(4'(i), 1, 1);
    press(4'h5, 50, 2);
    press(4'hF, 2, 1);
    for (int i = 1; i <= 8; i++) press(4'(i), 1 + (i % 3), 1);
    press(4'h9, 1, 1);
    repeat (40) @(negedge clk);
    press(4'hF, 1, 1);
    press(4'h1, 1, 1);
    press(4'h2, 1, 1);
    for (int i = 0; i < 3; i++) press(4'hE, 1, 1);
    for (int i = 1; i <= 5; i++) press(4'(i), 1, 1);
    press(4'hF, 1, 1);
    repeat (40) @(negedge clk);

    // Random traffic weighted toward digits so the buffer fills and overflows.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 72)      press(4'($urandom_range(0, 13)), $urandom_range(1, 5), $urandom_range(1, 4));
      else if (r < 90) press(4'hE, $urandom_range(1, 5), $urandom_range(1, 4));
      else             press(4'hF, $urandom_range(1, 5), $urandom_range(1, 4));
    end
    drain();

    // Fill, let the scan run, then reset mid-cycle with the key held down.
    press(4'hF, 1, 1);
    for (int i = 1; i <= 8; i++) press(4'(i), 1, 1);
    repeat (13) @(negedge clk);
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    key   = 4'h7;
    dav   = 1'b1;
    #1;
    check("async_rst_an", 32'(an_o), 32'hFF);
    check("async_rst_seg", 32'(seg_o), 32'h7F);
    check("async_rst_count", 32'(count_o), 32'd0);
    check("async_rst_digits", digits_o, 32'h0);
    mdl.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    void'(model_apply(4'h7));
    push_exp(1, 1'b0);
    push_exp(2, 1'b0);
    repeat (5) @(negedge clk);
    push_exp(6, 1'b0);
    dav = 1'b0;
    repeat (3) @(negedge clk);
    drain();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
